// File: rtl/registro_scorrimento_par_pkg.sv
// registro_scorrimento_par_pkg: shared command and controller state encodings
package registro_scorrimento_par_pkg;
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } op_t;
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/registro_scorrimento_par_if.sv
// registro_scorrimento_par_if: command/data bundle of the shift register.
// master drives start/op/d/n/si and observes q/so/busy/done; slave is the register side.
interface registro_scorrimento_par_if
    import registro_scorrimento_par_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          start;
    op_t           op;
    logic [W-1:0]  d;
    logic [CW-1:0] n;
    logic          si;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;
    modport master(output start, op, d, n, si, input q, so, busy, done);
    modport slave(input start, op, d, n, si, output q, so, busy, done);
endinterface

// File: rtl/registro_scorrimento_par_registro_w.sv
// registro_w: W-bit D register with load enable and async active-low reset.
// Ports: clock, reset_ (active-low, async), en (load enable), d (next value), q (contents).
module registro_w #(
    parameter int             W           = 8,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge reset_)
        if (!reset_) q <= RESET_VALUE;
        else if (en) q <= d;
endmodule

// File: rtl/registro_scorrimento_par.sv
// registro_scorrimento_par: W-bit register with parallel load and multi-step shift/rotate.
// Ports: clock, reset_ (active-low, async), bus (slave: start/op/d/n/si in, q/so/busy/done out).
module registro_scorrimento_par
    import registro_scorrimento_par_pkg::*;
#(
    parameter int           W           = 8,
    parameter int           CW          = 4,
    parameter logic [W-1:0] RESET_VALUE = '0
) (
    input logic                         clock,
    input logic                         reset_,
    registro_scorrimento_par_if.slave   bus
);
    state_t        state, state_n;
    op_t           op_r, op_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          so, so_n, busy, busy_n, done, done_n, q_en;
    logic [W-1:0]  q, q_nxt, stepped;
    registro_w #(.W(W), .RESET_VALUE(RESET_VALUE)) u_reg (
        .clock(clock),
        .reset_(reset_),
        .en(q_en),
        .d(q_nxt),
        .q(q)
    );
    always_ff @(posedge clock or negedge reset_)
        if (!reset_) begin
            state <= S_IDLE;
            op_r  <= OP_LOAD;
            cnt   <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            op_r  <= op_n;
            cnt   <= cnt_n;
            so    <= so_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    always_comb begin
        // one step of the latched command; the bit fed in at the MSB is si or the old LSB
        stepped = op_r == OP_SHL ? {q[W-2:0], bus.si}
                                 : {op_r == OP_ROR ? q[0] : bus.si, q[W-1:1]};
        state_n = state;
        op_n    = op_r;
        cnt_n   = cnt;
        so_n    = so;
        busy_n  = busy;
        done_n  = 1'b0;
        q_en    = 1'b0;
        q_nxt   = stepped;
        if (state == S_IDLE) begin
            if (bus.start) begin
                if (bus.op == OP_LOAD) begin
                    q_en   = 1'b1;
                    q_nxt  = bus.d;
                    done_n = 1'b1;
                end else if (bus.n == '0) begin
                    done_n = 1'b1;
                end else begin
                    state_n = S_SHIFT;
                    op_n    = bus.op;
                    cnt_n   = bus.n;
                    busy_n  = 1'b1;
                end
            end
        end else begin
            q_en  = 1'b1;
            so_n  = op_r == OP_SHL ? q[W-1] : q[0];
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end
    end
    assign bus.q    = q;
    assign bus.so   = so;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_registro_scorrimento_par.sv
// tb_registro_scorrimento_par: scoreboard bench with a stream-based reference model.
module tb_registro_scorrimento_par;
    import registro_scorrimento_par_pkg::*;
    localparam int W  = 8;
    localparam int CW = 4;
    typedef struct packed {
        logic [W-1:0] q;
        logic         so;
    } exp_t;
    logic clock = 1'b0;
    logic reset_ = 1'b0;
    always #5 clock = ~clock;
    registro_scorrimento_par_if #(.W(W), .CW(CW)) bus ();
    registro_scorrimento_par #(.W(W), .CW(CW), .RESET_VALUE('0)) dut (
        .clock(clock),
        .reset_(reset_),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [W-1:0] mq;
    logic mso;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    // Shifts are modelled as a window sliding over the bit stream {si..., q};
    // rotation as a modulo-W circular shift.
    function automatic exp_t model(logic [W-1:0] q0, logic so0, op_t op, logic [W-1:0] d, int n, bit sv[16]);
        logic [W+15:0] s;
        exp_t r;
        int k;
        r.q = q0;
        r.so = so0;
        if (op == OP_LOAD) begin
            r.q = d;
            return r;
        end
        if (n == 0) return r;
        case (op)
            OP_SHR: begin
                s = {16'b0, q0};
                for (int i = 0; i < n; i++) s[W+i] = sv[i];
                r.q = s[n +: W];
                r.so = s[n-1];
            end
            OP_SHL: begin
                s = {16'b0, q0} << n;
                for (int i = 0; i < n; i++) s[n-1-i] = sv[i];
                r.q = s[W-1:0];
                r.so = s[W];
            end
            default: begin
                k = n % W;
                r.q = (q0 >> k) | (q0 << (W - k));
                r.so = q0[(n-1) % W];
            end
        endcase
        return r;
    endfunction
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_) begin
            chk("busy_done_excl", 32'(bus.busy & bus.done), 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done got done=1 expected no pending command");
                end else begin
                    e = sb.pop_front();
                    chk("done_q", 32'(bus.q), 32'(e.q));
                    chk("done_so", 32'(bus.so), 32'(e.so));
                end
            end
        end
    end
    // Called at a negedge; returns at the negedge after the command finishes,
    // so consecutive calls issue back-to-back during the done cycle.
    task automatic cmd(op_t op, logic [W-1:0] d, int n, bit rnd, logic [15:0] pat);
        bit sv[16];
        exp_t e;
        for (int i = 0; i < 16; i++) sv[i] = rnd ? bit'($urandom_range(0, 1)) : pat[i];
        bus.start = 1'b1;
        bus.op = op;
        bus.d = d;
        bus.n = CW'(n);
        bus.si = 1'($urandom_range(0, 1));
        if (op == OP_LOAD || n == 0) begin
            e = model(mq, mso, op, d, n, sv);
            mq = e.q;
            mso = e.so;
            sb.push_back(e);
        end
        @(posedge clock);
        if (op != OP_LOAD && n > 0) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clock);
                chk("busy_during_shift", 32'(bus.busy), 1);
                if (i > 0) begin
                    e = model(mq, mso, op, d, i, sv);
                    chk("step_q", 32'(bus.q), 32'(e.q));
                end
                bus.si = sv[i];
                bus.start = 1'($urandom_range(0, 1));
                bus.op = op_t'($urandom_range(0, 3));
                bus.n = CW'($urandom);
                bus.d = W'($urandom);
                if (i == n - 1) begin
                    e = model(mq, mso, op, d, n, sv);
                    mq = e.q;
                    mso = e.so;
                    sb.push_back(e);
                end
                @(posedge clock);
            end
        end
        @(negedge clock);
        bus.start = 1'b0;
        chk("busy_after", 32'(bus.busy), 0);
    endtask
    task automatic idle();
        bus.start = 1'b0;
        bus.op = op_t'($urandom_range(0, 3));
        bus.d = W'($urandom);
        @(posedge clock);
        @(negedge clock);
        chk("idle_hold_q", 32'(bus.q), 32'(mq));
        chk("idle_busy", 32'(bus.busy), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.start = 1'b0;
        bus.op = OP_LOAD;
        bus.d = '0;
        bus.n = '0;
        bus.si = 1'b0;
        mq = '0;
        mso = 1'b0;
        #3;
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_so", 32'(bus.so), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        cmd(OP_LOAD, 8'h5A, 0, 1'b1, 16'h0);
        bus.start = 1'b1;
        bus.op = OP_SHR;
        bus.n = CW'(5);
        bus.si = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #2 reset_ = 1'b0;
        #1;
        chk("abort_q", 32'(bus.q), 0);
        chk("abort_so", 32'(bus.so), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        mq = '0;
        mso = 1'b0;
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        cmd(OP_LOAD, 8'h3C, 0, 1'b1, 16'h0);
        cmd(OP_LOAD, 8'hA5, 0, 1'b1, 16'h0);
        cmd(OP_SHR, 8'h00, 3, 1'b0, 16'hFFFF);
        cmd(OP_LOAD, 8'h81, 0, 1'b1, 16'h0);
        cmd(OP_ROR, 8'h00, 8, 1'b1, 16'h0);
        cmd(OP_LOAD, 8'h81, 0, 1'b1, 16'h0);
        cmd(OP_SHL, 8'h00, 2, 1'b0, 16'h0001);
        cmd(OP_SHL, 8'h00, 0, 1'b1, 16'h0);
        cmd(OP_LOAD, 8'hC3, 0, 1'b1, 16'h0);
        idle();
        for (int t = 0; t < 60; t++) begin
            cmd(op_t'($urandom_range(0, 3)), W'($urandom), int'($urandom_range(0, 15)), 1'b1, 16'h0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
